// File: rtl/i2c_register_writer.sv
// Single-shot I2C master that writes one data byte to one register of a 7-bit slave.
// Optional build macro I2C_REGISTER_WRITER_NACK_ABORT_EN: a NACK ends the transfer with STOP.
module i2c_register_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [6:0] slave_address,
  input  logic [7:0] register_address,
  input  logic [7:0] databyte_to_register,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       ack_1,
  output logic       ack_2,
  output logic       ack_3,
  output logic       nack_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

  logic [2:0] state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] phase, phase_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [1:0] byte_idx, byte_idx_n;
  logic [6:0] addr_q;
  logic [7:0] reg_q;
  logic [7:0] data_q;
  logic [7:0] tx_byte;
  logic       q_end;
  logic       last_q;
  logic       scl_n;
  logic       sda_n;
  logic       busy_n;
  logic       ack_sample;

  assign q_end      = (cnt == CNT_MAX);
  assign last_q     = q_end && (phase == 2'd3);
  assign ack_sample = (state == S_ACK) && (phase == 2'd2) && q_end;

`ifdef I2C_REGISTER_WRITER_NACK_ABORT_EN
  logic cur_ack;
  // The slot's ACK is registered at the end of q2, so it is valid by the end of q3.
  always_comb begin
    cur_ack = ack_3;
    case (byte_idx)
      2'd0:    cur_ack = ack_1;
      2'd1:    cur_ack = ack_2;
      default: cur_ack = ack_3;
    endcase
  end
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = 8'd0;
    phase_n    = 2'd0;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    if (state == S_START || state == S_BIT || state == S_ACK || state == S_STOP) begin
      if (q_end) begin
        cnt_n   = 8'd0;
        phase_n = phase + 2'd1;
      end else begin
        cnt_n   = cnt + 8'd1;
        phase_n = phase;
      end
    end
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_START;
          bit_idx_n  = 3'd7;
          byte_idx_n = 2'd0;
        end
      end
      S_START: begin
        if (last_q) begin
          state_n    = S_BIT;
          bit_idx_n  = 3'd7;
          byte_idx_n = 2'd0;
        end
      end
      S_BIT: begin
        if (last_q) begin
          if (bit_idx == 3'd0) state_n = S_ACK;
          else bit_idx_n = bit_idx - 3'd1;
        end
      end
      S_ACK: begin
        if (last_q) begin
`ifdef I2C_REGISTER_WRITER_NACK_ABORT_EN
          if (!cur_ack || byte_idx == 2'd2) begin
`else
          if (byte_idx == 2'd2) begin
`endif
            state_n = S_STOP;
          end else begin
            state_n    = S_BIT;
            bit_idx_n  = 3'd7;
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (last_q) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = data_q;
    case (byte_idx_n)
      2'd0:    tx_byte = {addr_q, 1'b0};
      2'd1:    tx_byte = reg_q;
      default: tx_byte = data_q;
    endcase
  end

  // Bus levels are computed for the state/phase being entered so the pins stay registered.
  always_comb begin
    scl_n  = 1'b1;
    sda_n  = 1'b1;
    busy_n = 1'b1;
    case (state_n)
      S_START: sda_n = ~phase_n[1];
      S_BIT: begin
        scl_n = phase_n[1];
        sda_n = tx_byte[bit_idx_n];
      end
      S_ACK:   scl_n = phase_n[1];
      S_STOP: begin
        scl_n = (phase_n != 2'd0);
        sda_n = phase_n[1];
      end
      default: busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      phase      <= 2'd0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      addr_q     <= 7'd0;
      reg_q      <= 8'd0;
      data_q     <= 8'd0;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_1      <= 1'b0;
      ack_2      <= 1'b0;
      ack_3      <= 1'b0;
      nack_error <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      scl_o    <= scl_n;
      sda_o    <= sda_n;
      busy     <= busy_n;
      done     <= (state_n == S_DONE);
      if (state == S_IDLE && start) begin
        addr_q     <= slave_address;
        reg_q      <= register_address;
        data_q     <= databyte_to_register;
        ack_1      <= 1'b0;
        ack_2      <= 1'b0;
        ack_3      <= 1'b0;
        nack_error <= 1'b0;
      end
      if (ack_sample) begin
        case (byte_idx)
          2'd0:    ack_1 <= ~sda_i;
          2'd1:    ack_2 <= ~sda_i;
          default: ack_3 <= ~sda_i;
        endcase
        if (sda_i) nack_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_register_writer.sv
// Bench for i2c_register_writer: bus monitor with byte scoreboard, slave ACK model,
// table of transactions plus reset and start-while-busy sequences.
module tb_i2c_register_writer;

  localparam int D = 4;
`ifdef I2C_REGISTER_WRITER_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [6:0] slave_address;
  logic [7:0] register_address;
  logic [7:0] databyte_to_register;
  logic       sda_i;
  logic       scl_o, sda_o, busy, done, ack_1, ack_2, ack_3, nack_error;

  logic       slave_pull = 1'b0;
  logic [2:0] slave_mask = 3'b111;
  assign sda_i = sda_o & ~slave_pull;

  i2c_register_writer #(.CLK_DIV(D)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .slave_address(slave_address), .register_address(register_address),
    .databyte_to_register(databyte_to_register), .sda_i(sda_i),
    .scl_o(scl_o), .sda_o(sda_o), .busy(busy), .done(done),
    .ack_1(ack_1), .ack_2(ack_2), .ack_3(ack_3), .nack_error(nack_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passes++;
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] rg;
    logic [7:0] dat;
    logic [2:0] mask;
    logic [2:0] exp_ack;
    logic       exp_nack;
    int         nbytes;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d,
                              input logic [2:0] m);
    vec_t v;
    int k;
    k = 3;
    for (int i = 2; i >= 0; i--) if (!m[i]) k = i;
    v.addr = a; v.rg = r; v.dat = d; v.mask = m;
    v.nbytes = (ABORT && k < 3) ? k + 1 : 3;
    for (int i = 0; i < 3; i++) v.exp_ack[i] = m[i] && (i < v.nbytes);
    v.exp_nack = (k < 3);
    v.exp_cycles = (8 + 36 * v.nbytes) * D;
    return v;
  endfunction

  // Scoreboard: bytes expected on SDA, in order.
  logic [7:0] exp_q[$];
  int   start_cnt = 0;
  int   stop_cnt = 0;
  int   done_cnt = 0;
  int   rise_cnt = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  logic [8:0] shreg = 9'd0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (prev_scl && scl_o && prev_sda && !sda_o) begin
      start_cnt++;
      rise_cnt = 0;
    end else if (prev_scl && scl_o && !prev_sda && sda_o) begin
      stop_cnt++;
    end
    if (!prev_scl && scl_o) begin
      shreg = {shreg[7:0], sda_o};
      rise_cnt++;
      if (rise_cnt % 9 == 0 && rise_cnt <= 27) begin
        if (exp_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("sda_byte", 32'(shreg[8:1]), 32'(e));
          check("ack_slot_released", 32'(shreg[0]), 32'd1);
        end
      end
    end
    if (prev_scl && !scl_o)
      slave_pull = (rise_cnt == 8 || rise_cnt == 17 || rise_cnt == 26) && !slave_mask[rise_cnt / 9];
    if (done) done_cnt++;
    prev_scl = scl_o;
    prev_sda = sda_o;
  end

  task automatic run_txn(input vec_t v, input int poke);
    int s0, p0, d0, cyc;
    bit got;
    s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
    exp_q.push_back({v.addr, 1'b0});
    if (v.nbytes > 1) exp_q.push_back(v.rg);
    if (v.nbytes > 2) exp_q.push_back(v.dat);
    slave_mask = ~v.mask;
    @(negedge clk);
    slave_address = v.addr; register_address = v.rg; databyte_to_register = v.dat;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 200 * D + 100; n++) begin
      @(posedge clk); #1;
      if (n == poke) begin
        start = 1'b1;
        slave_address = 7'($urandom_range(0, 127));
        register_address = 8'($urandom_range(0, 255));
        databyte_to_register = 8'($urandom_range(0, 255));
      end else start = 1'b0;
      if (done) begin
        got = 1'b1;
        cyc = n;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("done_cycle", cyc, v.exp_cycles);
    check("acks_at_done", 32'({ack_3, ack_2, ack_1}), 32'(v.exp_ack));
    check("nack_at_done", 32'(nack_error), 32'(v.exp_nack));
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_bus", 32'({scl_o, sda_o}), 32'h3);
    repeat (5) @(posedge clk);
    #1;
    check("acks_hold", 32'({nack_error, ack_3, ack_2, ack_1}), 32'({v.exp_nack, v.exp_ack}));
    check("start_count", start_cnt - s0, 1);
    check("stop_count", stop_cnt - p0, 1);
    check("done_count", done_cnt - d0, 1);
    check("frames_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    resetn = 1'b0; start = 1'b0;
    slave_address = 7'd0; register_address = 8'd0; databyte_to_register = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl_o), 32'd1);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_acks", 32'({nack_error, ack_3, ack_2, ack_1}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    vecs[0] = mk(7'h50, 8'h10, 8'hA5, 3'b111);
    vecs[1] = mk(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b110);
    vecs[2] = mk(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b101);
    vecs[3] = mk(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'b011);
    vecs[4] = mk(7'h7F, 8'h00, 8'hFF, 3'b000);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], 0);

    // start pulsed while busy must not disturb the captured bytes or add a done
    run_txn(vecs[0], 100);

    // reset in the middle of a transaction
    d0 = done_cnt;
    exp_q.push_back({vecs[0].addr, 1'b0});
    slave_mask = 3'b000;
    @(negedge clk);
    slave_address = vecs[0].addr; register_address = vecs[0].rg;
    databyte_to_register = vecs[0].dat;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_bus", 32'({scl_o, sda_o}), 32'h3);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    exp_q.delete();

    run_txn(vecs[1], 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2c_register_writer.md
I2C_REGISTER_WRITER -- requirements
Module: i2c_register_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a write transaction; sampled only when busy=0.
REQ-005 SHALL have port slave_address  input  7  target address; captured on the accepted start.
REQ-006 SHALL have port register_address  input  8  register index; captured on the accepted start.
REQ-007 SHALL have port databyte_to_register  input  8  data byte; captured on the accepted start.
REQ-008 SHALL have port sda_i  input  1  sampled bus SDA level.
REQ-009 SHALL have port scl_o  output  1  SCL drive; 1 = released, 0 = pull low.
REQ-010 SHALL have port sda_o  output  1  SDA drive; 1 = released, 0 = pull low.
REQ-011 SHALL have port busy  output  1  transaction in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-013 SHALL have ports ack_1, ack_2, ack_3  output  1 each  ACK seen after address, register and data bytes.
REQ-014 SHALL have port nack_error  output  1  at least one NACK seen in the last transaction.

Function
REQ-015 SHALL implement states IDLE, START, BIT, ACK, STOP, DONE.
REQ-016 Quarter counter SHALL count 0..CLK_DIV-1; phase counter SHALL advance q0..q3 on wrap.
REQ-017 IDLE: start=1 SHALL capture inputs, clear ack_1..3 and nack_error, set busy, and enter START.
REQ-018 START (q0..q3): scl_o=1 throughout; sda_o=1 in q0-q1 and 0 in q2-q3.
REQ-019 BIT: scl_o=0 in q0-q1 and 1 in q2-q3; sda_o SHALL change only at the q0 boundary; bits are sent MSB first.
REQ-020 Byte 0 SHALL be {slave_address, 1'b0} (write); byte 1 register_address; byte 2 databyte_to_register.
REQ-021 ACK: sda_o=1 (released); sda_i SHALL be sampled on the last clk of q2; ack_n <= ~sda_i; sda_i=1 SHALL set nack_error.
REQ-022 After ACK of byte 0 or 1, the FSM SHALL go to BIT for the next byte; after ACK of byte 2 it SHALL go to STOP.
REQ-023 STOP: q0 scl_o=0 sda_o=0; q1 scl_o=1 sda_o=0; q2-q3 scl_o=1 sda_o=1.
REQ-024 DONE SHALL last one cycle: done=1, busy=0, then IDLE. Full transaction: done exactly 116*CLK_DIV cycles after the accepted start.
REQ-025 start while busy=1 SHALL be ignored, not queued.
REQ-026 Outputs SHALL be registered; ack_1..3 and nack_error SHALL hold until the next accepted start.
REQ-027 In IDLE: scl_o=1, sda_o=1, busy=0, done=0.

Reset
REQ-028 resetn=0 at any clk edge SHALL force IDLE; scl_o=1, sda_o=1, busy=0, done=0, ack_1..3=0, nack_error=0, counters=0.
REQ-029 Reset mid-transaction SHALL abandon it without generating STOP and without a done pulse.

Configuration
REQ-030 Macro I2C_REGISTER_WRITER_NACK_ABORT_EN: when defined, a NACK in any ACK slot SHALL go directly to STOP, then DONE; remaining bytes are not sent.
REQ-031 Without the macro, a NACK SHALL only set nack_error, and the transaction SHALL complete all three bytes.

Verification
REQ-032 CLK_DIV=4, addr 0x50, reg 0x10, data 0xA5, slave ACKs all -> SDA bytes 0xA0, 0x10, 0xA5; ack_1..3=1; nack_error=0; done at cycle 464.
REQ-033 With macro defined, same stimulus but sda_i=1 in ACK slot 1 -> STOP right after bit 9; ack_1=0; nack_error=1; done at cycle 176.
REQ-034 Without macro, same NACK -> all 27 bits sent; ack_1=0; ack_2=ack_3=1; nack_error=1; done at cycle 464.
REQ-035 resetn=0 at cycle 200 of a transaction -> next cycle scl_o=sda_o=1, busy=0, no done pulse; a new start after release runs normally.
REQ-036 start pulsed at cycle 100 while busy -> ignored; captured data unchanged; exactly one done pulse.
REQ-037 Protocol checker: SDA never toggles while scl_o=1 during BIT or ACK; exactly one START and one STOP per transaction.
